fnd_scan_controller: RTL and testbench
======================================

Name: fnd_scan_controller

Overview:
- Parametrised FND (7-segment) scan controller for N digits, with a sequential binary-to-BCD (double-dabble) converter.
- Captures a binary value on a load pulse, converts it over multiple cycles, commits BCD digits to display registers, and time-multiplexes them onto shared segment lines.
- Sits between the AXI register block and the board FND pins.
- Adds saturation, per-digit decimal points, a busy flag and display enable.

Parameters:
- DIGITS, 4, number of digits scanned (2..8)
- VALUE_W, 14, input binary width
- CLK_HZ, 100_000_000, i_clk frequency
- SCAN_HZ, 1000, digit-advance rate; prescaler terminal count = CLK_HZ/SCAN_HZ-1

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_value  in  VALUE_W  binary value to display
- i_load  in  1  one-cycle pulse; captures i_value and starts conversion
- i_clear  in  1  synchronous clear of display and converter
- i_enable  in  1  1 = display on, 0 = all digits off
- i_dp  in  DIGITS  decimal point per digit, 1 = lit (bit 0 = least significant digit)
- o_busy  out  1  conversion in progress
- o_fnd_digit  out  DIGITS  digit select, one-hot active-low
- o_fnd_font  out  8  segments {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (i_reset=0, async):
  - o_fnd_digit all ones, o_fnd_font 8'hFF, o_busy 0.
  - Display registers 0, digit index 0, prescaler 0, FSM IDLE.
- Converter FSM, IDLE -> SHIFT -> COMMIT -> IDLE:
  - IDLE: i_load=1 captures i_value, clears the BCD shift register, sets o_busy next cycle, goes to SHIFT.
  - SHIFT: VALUE_W cycles. Each cycle adds 3 to every BCD nibble >=5, then shifts left one bit from the captured value.
  - COMMIT: one cycle. If the value exceeds 10^DIGITS-1 (any carry above nibble DIGITS-1), all display nibbles load 9 (saturation). Otherwise the low DIGITS nibbles load. o_busy drops the cycle after COMMIT.
  - Latency: load pulse at cycle 0; display registers hold new digits from cycle VALUE_W+2; o_busy high for VALUE_W+1 cycles.
- i_load while o_busy=1: ignored; the in-flight conversion completes unchanged.
- i_clear=1:
  - Display registers go to 0, FSM to IDLE, o_busy to 0 next cycle, aborting any conversion.
  - Has priority over a simultaneous i_load.
  - Scan counters unaffected.
- Scan:
  - Prescaler counts 0..CLK_HZ/SCAN_HZ-1 and emits a 1-cycle tick at terminal count.
  - Each tick advances the digit index, wrapping DIGITS-1 -> 0.
  - Scan runs regardless of i_enable and o_busy.
- Outputs:
  - Registered, updated one cycle after the index changes.
  - o_fnd_digit = ~(1<<index).
  - Font = standard active-low hex decode of the nibble (0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90).
  - Bit 7 = ~i_dp[index].
- i_enable=0: o_fnd_digit all ones, o_fnd_font 8'hFF. Index keeps advancing.
- Display registers change only in COMMIT or on clear, so no partial values are ever shown.

Optional Feature:
- Macro: FND_LEADING_ZERO_BLANK_EN.
- Defined: any digit more significant than the highest non-zero committed digit shows font segments 7'h7F (dark). Its dp still follows i_dp. Digit 0 is never blanked, so value 0 shows "0". Blanking is computed from the display registers at COMMIT and on clear.
- Undefined: all DIGITS digits are always shown, including leading zeros.

Test Plan:
- Reset: assert i_reset=0 mid-scan -> o_fnd_digit=4'b1111, o_fnd_font=8'hFF, o_busy=0 immediately. Release -> first digit 4'b1110 shows C0.
- Conversion (CLK_HZ=1000, SCAN_HZ=100, tick every 10 cycles): pulse i_load with 1234 -> o_busy high for 15 cycles. Scan then shows digit 4'b1110/99, 4'b1101/B0, 4'b1011/A4, 4'b0111/F9.
- Saturation: load 16383 -> every digit shows 90. Load 9999 -> every digit shows 90 with no overflow.
- Clear mid-conversion: i_load with 5678, then i_clear on cycle 5 -> o_busy=0 next cycle; all digits C0. A second i_load in the same cycle as i_clear is ignored.
- Load while busy plus decimal points: second i_load of 42 during a conversion of 1234 -> display 1234. With i_dp=4'b0100, digit 2 font = 24.
- Enable / blank: i_enable=0 -> digits 1111, font FF, index still advancing. With FND_LEADING_ZERO_BLANK_EN, load 7 -> digit0 F8, digits 1-3 FF.

Source files
------------

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: captures a binary value, converts it to BCD with a
// sequential double-dabble, and time-multiplexes the committed digits onto
// shared active-low 7-segment lines.
// Optional feature macro: FND_LEADING_ZERO_BLANK_EN (blank leading zero digits).
module fnd_scan_controller #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned VALUE_W = 14,
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic               i_enable,
  input  logic [DIGITS-1:0]  i_dp,
  output logic               o_busy,
  output logic [DIGITS-1:0]  o_fnd_digit,
  output logic [7:0]         o_fnd_font
);

  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(VALUE_W + 1);
  localparam int unsigned PRE_TC = CLK_HZ / SCAN_HZ - 1;
  localparam int unsigned PRE_W  = (PRE_TC > 0) ? $clog2(PRE_TC + 1) : 1;
  localparam int unsigned IDX_W  = $clog2(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [VALUE_W-1:0] val_q, val_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   adj;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               busy_q, busy_d;

  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [3:0]         nib;
  logic [DIGITS-1:0]  digit_q, digit_d;
  logic [7:0]         font_q, font_d;

  // Active-low a..g segment pattern for one hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0:    seg7 = 7'h40;
      4'h1:    seg7 = 7'h79;
      4'h2:    seg7 = 7'h24;
      4'h3:    seg7 = 7'h30;
      4'h4:    seg7 = 7'h19;
      4'h5:    seg7 = 7'h12;
      4'h6:    seg7 = 7'h02;
      4'h7:    seg7 = 7'h78;
      4'h8:    seg7 = 7'h00;
      4'h9:    seg7 = 7'h10;
      4'hA:    seg7 = 7'h08;
      4'hB:    seg7 = 7'h03;
      4'hC:    seg7 = 7'h46;
      4'hD:    seg7 = 7'h21;
      4'hE:    seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // Converter next-state: capture, add-3/shift, commit (with saturation), clear.
  // A bit shifted out of the top nibble means the value cannot fit in DIGITS
  // decimal digits; it is kept sticky in ovf and forces all-nines at commit.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    adj     = bcd_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    case (state_q)
      S_IDLE: begin
        if (i_load) begin
          state_d = S_SHIFT;
          val_d   = i_value;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        bcd_d = {adj[BCD_W-2:0], val_q[VALUE_W-1]};
        ovf_d = ovf_q | adj[BCD_W-1];
        val_d = val_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        disp_d  = ovf_q ? {DIGITS{4'd9}} : bcd_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_clear) begin
      state_d = S_IDLE;
      disp_d  = '0;
    end
    busy_d = (state_d != S_IDLE);
  end

  // Converter and display registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      disp_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      busy_q  <= busy_d;
    end
  end

  // Scan prescaler and digit index; free-running regardless of enable/busy.
  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (presc_q == PRE_W'(PRE_TC)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Scan counter registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

`ifdef FND_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              seen;

  // Blank mask follows the display registers: digits above the top non-zero one.
  always_comb begin
    blank_d = '0;
    seen    = 1'b0;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      if (disp_d[4*k +: 4] != 4'd0) seen = 1'b1;
      blank_d[k] = ~seen;
    end
  end

  // Blank mask register; reset matches an all-zero display.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
    else          blank_q <= blank_d;
  end
`endif

  // Segment/digit drive for the current index.
  always_comb begin
    digit_d = '1;
    font_d  = 8'hFF;
    nib     = disp_q[{idx_q, 2'b00} +: 4];
    if (i_enable) begin
      digit_d = ~(DIGITS'(1) << idx_q);
      font_d  = {~i_dp[idx_q], seg7(nib)};
`ifdef FND_LEADING_ZERO_BLANK_EN
      if (blank_q[idx_q]) font_d[6:0] = 7'h7F;
`endif
    end
  end

  // Output registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      digit_q <= '1;
      font_q  <= 8'hFF;
    end else begin
      digit_q <= digit_d;
      font_q  <= font_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_fnd_digit = digit_q;
  assign o_fnd_font  = font_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: directed steps plus randomized loads, checked
// every cycle against a decimal/timing reference model.
module tb_fnd_scan_controller;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned VALUE_W = 14;
  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned SCAN_HZ = 100;
  localparam int          PERIOD  = int'(CLK_HZ / SCAN_HZ);
  localparam int          ND      = int'(DIGITS);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [VALUE_W-1:0] i_value = '0;
  logic               i_load = 1'b0;
  logic               i_clear = 1'b0;
  logic               i_enable = 1'b1;
  logic [DIGITS-1:0]  i_dp = '0;
  logic               o_busy;
  logic [DIGITS-1:0]  o_fnd_digit;
  logic [7:0]         o_fnd_font;

  fnd_scan_controller #(
    .DIGITS (DIGITS),
    .VALUE_W(VALUE_W),
    .CLK_HZ (CLK_HZ),
    .SCAN_HZ(SCAN_HZ)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_value    (i_value),
    .i_load     (i_load),
    .i_clear    (i_clear),
    .i_enable   (i_enable),
    .i_dp       (i_dp),
    .o_busy     (o_busy),
    .o_fnd_digit(o_fnd_digit),
    .o_fnd_font (o_fnd_font)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state.
  int                m_edges     = 0;
  int                m_busy_left = 0;
  int                m_pending   = 0;
  int                m_disp [ND];
  logic [DIGITS-1:0] m_exp_digit = '1;
  logic [7:0]        m_exp_font  = 8'hFF;
  logic              m_exp_busy  = 1'b0;

  logic [7:0] font_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_edges     = 0;
    m_busy_left = 0;
    m_pending   = 0;
    for (int k = 0; k < ND; k++) m_disp[k] = 0;
    m_exp_digit = '1;
    m_exp_font  = 8'hFF;
    m_exp_busy  = 1'b0;
  endtask

  // Decimal digits of v, or all nines when v does not fit.
  task automatic set_display(input int v);
    int lim;
    int r;
    lim = 1;
    for (int k = 0; k < ND; k++) lim = lim * 10;
    r = v;
    for (int k = 0; k < ND; k++) begin
      if (v >= lim) m_disp[k] = 9;
      else begin
        m_disp[k] = r % 10;
        r = r / 10;
      end
    end
  endtask

  // One clock edge of the model: outputs from pre-edge state, then advance.
  task automatic model_edge();
    int        idx;
    bit        blank;
    logic [7:0] fnt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    idx   = (m_edges / PERIOD) % ND;
    blank = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
    if (idx != 0) begin
      blank = 1'b1;
      for (int j = idx; j < ND; j++) if (m_disp[j] != 0) blank = 1'b0;
    end
`endif
    if (i_enable) begin
      fnt         = font_tab[m_disp[idx]];
      m_exp_digit = ~(DIGITS'(1) << idx);
      m_exp_font  = {~i_dp[idx], blank ? 7'h7F : fnt[6:0]};
    end else begin
      m_exp_digit = '1;
      m_exp_font  = 8'hFF;
    end
    m_edges++;
    if (i_clear) begin
      m_busy_left = 0;
      for (int k = 0; k < ND; k++) m_disp[k] = 0;
    end else if (m_busy_left == 0) begin
      if (i_load) begin
        m_busy_left = int'(VALUE_W) + 1;
        m_pending   = int'(i_value);
      end
    end else begin
      m_busy_left--;
      if (m_busy_left == 0) set_display(m_pending);
    end
    m_exp_busy = (m_busy_left != 0);
  endtask

  task automatic check_all();
    chk("digit", 32'(o_fnd_digit), 32'(m_exp_digit));
    chk("font",  32'(o_fnd_font),  32'(m_exp_font));
    chk("busy",  32'(o_busy),      32'(m_exp_busy));
  endtask

  // Advance one clock: model at the edge, compare at the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic load_pulse(input int v);
    i_value = VALUE_W'(v);
    i_load  = 1'b1;
    cyc();
    i_load  = 1'b0;
  endtask

  initial begin
    int nb;
    int v;
    int w;
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    chk("rel_digit", 32'(o_fnd_digit), 32'h0000_000E);
    chk("rel_font",  32'(o_fnd_font),  32'h0000_00C0);
    repeat (25) cyc();

    // Asynchronous reset mid-scan.
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_digit", 32'(o_fnd_digit), 32'h0000_000F);
    chk("rst_font",  32'(o_fnd_font),  32'h0000_00FF);
    chk("rst_busy",  32'(o_busy),      32'h0000_0000);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    // Conversion of 1234 and busy length.
    load_pulse(1234);
    nb = o_busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (o_busy) nb++;
    end
    chk("busy_len", 32'(nb), 32'(VALUE_W + 1));
    repeat (40) cyc();

    // Saturation, and the largest value that fits.
    load_pulse(16383);
    repeat (20) cyc();
    for (int i = 0; i < 40; i++) begin
      cyc();
      chk("sat_font", 32'(o_fnd_font), 32'h0000_0090);
    end
    load_pulse(9999);
    repeat (20) cyc();
    for (int i = 0; i < 40; i++) begin
      cyc();
      chk("nines_font", 32'(o_fnd_font), 32'h0000_0090);
    end

    // Clear mid-conversion with a simultaneous load.
    load_pulse(5678);
    repeat (4) cyc();
    i_clear = 1'b1;
    i_load  = 1'b1;
    i_value = VALUE_W'(1111);
    cyc();
    chk("clr_busy", 32'(o_busy), 32'h0000_0000);
    i_clear = 1'b0;
    i_load  = 1'b0;
    repeat (50) cyc();

    // Load while busy is ignored; decimal point on digit 2.
    i_dp = 4'b0100;
    load_pulse(1234);
    repeat (3) cyc();
    load_pulse(42);
    repeat (60) cyc();
    i_dp = '0;

    // Display disabled, scan keeps running.
    i_enable = 1'b0;
    repeat (30) cyc();
    i_enable = 1'b1;
    repeat (45) cyc();

    // Small value (leading zeros).
    load_pulse(7);
    repeat (60) cyc();

    // Randomized loads, overlapping loads, clears, dp and enable.
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 9));
        1:       v = int'($urandom_range(10, 999));
        2:       v = int'($urandom_range(9000, 10100));
        default: v = int'($urandom_range(0, 16383));
      endcase
      i_dp     = DIGITS'($urandom);
      i_enable = ($urandom_range(0, 4) != 0);
      load_pulse(v);
      w = int'($urandom_range(3, 60));
      for (int c = 0; c < w; c++) begin
        i_load  = ($urandom_range(0, 7) == 0);
        i_clear = ($urandom_range(0, 39) == 0);
        i_value = VALUE_W'($urandom_range(0, 16383));
        cyc();
      end
      i_load  = 1'b0;
      i_clear = 1'b0;
    end
    i_enable = 1'b1;
    repeat (60) cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
